// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register controller: FSM encoding and default target address.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEVADDR = 3'd1,
        ST_REGADDR = 3'd2,
        ST_WRITE   = 3'd3,
        ST_READ    = 3'd4
    } state_t;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h2A;

endpackage

// File: rtl/i2c_reg_ctrl_if.sv
// Byte-level link between the I2C bit/byte engine (master) and the register controller (slave).
// Handshake: every *_valid / start / stop / tx_req signal is a single-cycle pulse; no backpressure exists.
interface i2c_reg_ctrl_if;
    logic       start_i;
    logic       stop_i;
    logic       rx_valid_i;
    logic [7:0] rx_data_i;
    logic       tx_req_i;
    logic       ack_valid_o;
    logic       ack_o;
    logic       tx_valid_o;
    logic [7:0] tx_data_o;

    modport master (
        output start_i, stop_i, rx_valid_i, rx_data_i, tx_req_i,
        input  ack_valid_o, ack_o, tx_valid_o, tx_data_o
    );

    modport slave (
        input  start_i, stop_i, rx_valid_i, rx_data_i, tx_req_i,
        output ack_valid_o, ack_o, tx_valid_o, tx_data_o
    );
endinterface

// File: rtl/i2c_regfile.sv
// Register storage: single write port with registered one-hot strobe, combinational read mux, flat output.
module i2c_regfile #(
    parameter int N_REGS = 8,
    parameter int ADDR_W = $clog2(N_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [7:0]            wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [7:0]            rdata_o,
    output logic [8*N_REGS-1:0]   regs_o,
    output logic [N_REGS-1:0]     wr_strobe_o
);

    logic [7:0]        regs_q [N_REGS];
    logic [7:0]        regs_d [N_REGS];
    logic [N_REGS-1:0] strobe_q;
    logic [N_REGS-1:0] strobe_d;

    always_comb begin
        regs_d   = regs_q;
        strobe_d = '0;
        if (we_i) begin
            regs_d[waddr_i]   = wdata_i;
            strobe_d[waddr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_REGS; k++) begin
                regs_q[k] <= 8'h00;
            end
            strobe_q <= '0;
        end else begin
            regs_q   <= regs_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int k = 0; k < N_REGS; k++) begin
            regs_o[8*k +: 8] = regs_q[k];
        end
    end

    assign rdata_o     = regs_q[raddr_i];
    assign wr_strobe_o = strobe_q;

endmodule

// File: rtl/i2c_reg_ctrl.sv
// I2C target register controller: decodes device address, register pointer and data bytes
// from the byte engine, answers with ACK/NACK and serves reads with an auto-incrementing pointer.
module i2c_reg_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
    parameter int         N_REGS   = 8,
    parameter int         ADDR_W   = $clog2(N_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    i2c_reg_ctrl_if.slave        bus,
    output logic [8*N_REGS-1:0]  regs_o,
    output logic [N_REGS-1:0]    wr_strobe_o,
    output state_t               state_o,
    output logic [ADDR_W-1:0]    ptr_o
);

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ack_valid_q, ack_valid_d;
    logic              ack_q, ack_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              we;
    logic [7:0]        rdata;

    i2c_regfile #(
        .N_REGS (N_REGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .we_i        (we),
        .waddr_i     (ptr_q),
        .wdata_i     (bus.rx_data_i),
        .raddr_i     (ptr_q),
        .rdata_o     (rdata),
        .regs_o      (regs_o),
        .wr_strobe_o (wr_strobe_o)
    );

    // start/stop take priority over any byte or request arriving in the same cycle.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ack_valid_d = 1'b0;
        ack_d       = 1'b0;
        tx_valid_d  = 1'b0;
        tx_data_d   = tx_data_q;
        we          = 1'b0;
        if (bus.start_i) begin
            state_d = ST_DEVADDR;
        end else if (bus.stop_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_DEVADDR: begin
                    if (bus.rx_valid_i) begin
                        ack_valid_d = 1'b1;
                        if (bus.rx_data_i[7:1] == DEV_ADDR) begin
                            ack_d   = 1'b1;
                            state_d = bus.rx_data_i[0] ? ST_READ : ST_REGADDR;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_REGADDR: begin
                    if (bus.rx_valid_i) begin
                        ack_valid_d = 1'b1;
                        if ((bus.rx_data_i >> ADDR_W) == 8'd0) begin
                            ptr_d   = bus.rx_data_i[ADDR_W-1:0];
                            ack_d   = 1'b1;
                            state_d = ST_WRITE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.rx_valid_i) begin
                        we          = 1'b1;
                        ptr_d       = ptr_q + PTR_ONE;
                        ack_valid_d = 1'b1;
                        ack_d       = 1'b1;
                    end
                end
                ST_READ: begin
                    if (bus.tx_req_i) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = rdata;
                        ptr_d      = ptr_q + PTR_ONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            ack_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ack_valid_q <= ack_valid_d;
            ack_q       <= ack_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign bus.ack_valid_o = ack_valid_q;
    assign bus.ack_o       = ack_q;
    assign bus.tx_valid_o  = tx_valid_q;
    assign bus.tx_data_o   = tx_data_q;
    assign state_o         = state_q;
    assign ptr_o           = ptr_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed scoreboard bench for i2c_reg_ctrl (DEV_ADDR 0x2A, 8 registers).
module tb_i2c_reg_ctrl;
    import i2c_pkg::*;

    localparam int N = 8;

    logic           clk;
    logic           reset;
    logic [8*N-1:0] regs_o;
    logic [N-1:0]   wr_strobe_o;
    state_t         state_o;
    logic [2:0]     ptr_o;

    i2c_reg_ctrl_if bus();

    i2c_reg_ctrl #(.DEV_ADDR(7'h2A), .N_REGS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .regs_o      (regs_o),
        .wr_strobe_o (wr_strobe_o),
        .state_o     (state_o),
        .ptr_o       (ptr_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [0:0]   ack_exp_q[$];
    logic [7:0]   tx_exp_q[$];
    logic [N-1:0] strb_exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reg(input int idx, input logic [7:0] exp);
        check($sformatf("reg%0d", idx), 64'(regs_o[8*idx +: 8]), 64'(exp));
    endtask

    // monitor: pops expected responses whenever the DUT pulses an output
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ack_valid_o) begin
                if (ack_exp_q.size() == 0) check("ack_unexpected", 64'd1, 64'd0);
                else check("ack_o", 64'(bus.ack_o), 64'(ack_exp_q.pop_front()));
            end
            if (bus.tx_valid_o) begin
                if (tx_exp_q.size() == 0) check("tx_unexpected", 64'd1, 64'd0);
                else check("tx_data_o", 64'(bus.tx_data_o), 64'(tx_exp_q.pop_front()));
            end
            if (wr_strobe_o != '0) begin
                if (strb_exp_q.size() == 0) check("strobe_unexpected", 64'(wr_strobe_o), 64'd0);
                else check("wr_strobe_o", 64'(wr_strobe_o), 64'(strb_exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic do_start();
        @(posedge clk); #1 bus.start_i = 1'b1;
        @(posedge clk); #1 bus.start_i = 1'b0;
    endtask

    task automatic do_stop();
        @(posedge clk); #1 bus.stop_i = 1'b1;
        @(posedge clk); #1 bus.stop_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] data, input bit has_ack, input bit exp_ack,
                             input logic [N-1:0] exp_strb);
        if (has_ack) ack_exp_q.push_back(exp_ack);
        if (exp_strb != '0) strb_exp_q.push_back(exp_strb);
        @(posedge clk); #1 bus.rx_valid_i = 1'b1; bus.rx_data_i = data;
        @(posedge clk); #1 bus.rx_valid_i = 1'b0;
    endtask

    task automatic tx_request(input bit has_tx, input logic [7:0] exp_data);
        if (has_tx) tx_exp_q.push_back(exp_data);
        @(posedge clk); #1 bus.tx_req_i = 1'b1;
        @(posedge clk); #1 bus.tx_req_i = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.start_i    = 1'b0;
        bus.stop_i     = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        bus.tx_req_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        check("rst_state", 64'(state_o), 64'(ST_IDLE));
        check("rst_ptr", 64'(ptr_o), 64'd0);
        check("rst_regs", 64'(regs_o), 64'd0);
        check("rst_tx_data", 64'(bus.tx_data_o), 64'd0);
        check("rst_pulses", 64'({bus.ack_valid_o, bus.ack_o, bus.tx_valid_o, wr_strobe_o}), 64'd0);

        // write reg2/reg3
        do_start();
        send_byte(8'h54, 1, 1, '0);
        send_byte(8'h02, 1, 1, '0);
        send_byte(8'hAA, 1, 1, 8'h04);
        check_reg(2, 8'hAA);
        send_byte(8'hBB, 1, 1, 8'h08);
        do_stop();
        check_reg(3, 8'hBB);
        check("wr_state_idle", 64'(state_o), 64'(ST_IDLE));
        check("wr_ptr", 64'(ptr_o), 64'd4);

        // write across the wrap: reg7, reg0, reg1
        do_start();
        send_byte(8'h54, 1, 1, '0);
        send_byte(8'h07, 1, 1, '0);
        send_byte(8'h77, 1, 1, 8'h80);
        send_byte(8'h11, 1, 1, 8'h01);
        send_byte(8'h22, 1, 1, 8'h02);
        do_stop();
        check("wrap_regs", 64'(regs_o), 64'h7700_0000_BBAA_2211);

        // tx_req while idle is ignored
        tx_request(0, 8'h00);

        // read with repeated start: reg7, reg0, reg1
        do_start();
        send_byte(8'h54, 1, 1, '0);
        send_byte(8'h07, 1, 1, '0);
        do_start();
        send_byte(8'h55, 1, 1, '0);
        check("rd_state", 64'(state_o), 64'(ST_READ));
        tx_request(1, 8'h77);
        tx_request(1, 8'h11);
        tx_request(1, 8'h22);
        do_stop();
        check("rd_ptr", 64'(ptr_o), 64'd2);

        // wrong device address
        do_start();
        send_byte(8'h56, 1, 0, '0);
        check("nack_state", 64'(state_o), 64'(ST_IDLE));
        send_byte(8'h02, 0, 0, '0);
        send_byte(8'h99, 0, 0, '0);
        do_stop();
        check("nack_regs", 64'(regs_o), 64'h7700_0000_BBAA_2211);

        // bad register index
        do_start();
        send_byte(8'h54, 1, 1, '0);
        send_byte(8'h09, 1, 0, '0);
        check("badidx_state", 64'(state_o), 64'(ST_IDLE));
        check("badidx_ptr", 64'(ptr_o), 64'd2);

        // stop collides with a data byte in WRITE
        do_start();
        send_byte(8'h54, 1, 1, '0);
        send_byte(8'h05, 1, 1, '0);
        @(posedge clk); #1 bus.stop_i = 1'b1; bus.rx_valid_i = 1'b1; bus.rx_data_i = 8'hCC;
        @(posedge clk); #1 bus.stop_i = 1'b0; bus.rx_valid_i = 1'b0;
        @(posedge clk); #1;
        check("coll_state", 64'(state_o), 64'(ST_IDLE));
        check_reg(5, 8'h00);
        check("coll_ptr", 64'(ptr_o), 64'd5);

        // reset in WRITE after one byte
        do_start();
        send_byte(8'h54, 1, 1, '0);
        send_byte(8'h01, 1, 1, '0);
        send_byte(8'h5A, 1, 1, 8'h02);
        check_reg(1, 8'h5A);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rstmid_regs", 64'(regs_o), 64'd0);
        check("rstmid_state", 64'(state_o), 64'(ST_IDLE));
        check("rstmid_ptr", 64'(ptr_o), 64'd0);
        send_byte(8'h54, 0, 0, '0);
        check("rstmid_after_state", 64'(state_o), 64'(ST_IDLE));

        // every expected response must have been seen
        repeat (4) @(posedge clk);
        check("ack_q_empty", 64'(ack_exp_q.size()), 64'd0);
        check("tx_q_empty", 64'(tx_exp_q.size()), 64'd0);
        check("strb_q_empty", 64'(strb_exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
